spi_flash_responder: RTL and testbench



---
 rtl/spi_flash_responder.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash target (READ 03, WRITE 02, WREN 06, RDSR 05) over a small byte array.
// All SPI pins are oversampled in the clk domain; no logic is clocked by spi_sclk.
module spi_flash_responder #(
   parameter int ADDR_BITS   = 8,
   parameter int PROG_CYCLES = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       spi_sclk,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       spi_miso_oe,
   output logic       busy,
   output logic [7:0] last_cmd
);
   localparam int DEPTH = 1 << ADDR_BITS;
   localparam int TW    = $clog2(PROG_CYCLES + 1);
   localparam logic [ADDR_BITS-1:0] PAGE_MASK = (ADDR_BITS > 8) ? ADDR_BITS'(8'hFF) : '1;

   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_RDSR  = 8'h05;
   localparam logic [7:0] OP_WREN  = 8'h06;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CMD    = 3'd1;
   localparam logic [2:0] S_ADDR   = 3'd2;
   localparam logic [2:0] S_STATUS = 3'd3;
   localparam logic [2:0] S_RDATA  = 3'd4;
   localparam logic [2:0] S_WDATA  = 3'd5;
   localparam logic [2:0] S_IGNORE = 3'd6;

   // RDSR is always answered; everything else is shut out while a program is in flight.
   function automatic logic [2:0] dispatch(input logic [7:0] op, input logic wip);
      logic [2:0] nxt;
      if (op == OP_RDSR) begin
         nxt = S_STATUS;
      end else if (wip) begin
         nxt = S_IGNORE;
      end else begin
         case (op)
            OP_READ, OP_WRITE: nxt = S_ADDR;
            default:           nxt = S_IGNORE;
         endcase
      end
      return nxt;
   endfunction

   // Page programming wraps within the low 8 address bits; upper bits hold.
   function automatic logic [ADDR_BITS-1:0] page_inc(input logic [ADDR_BITS-1:0] a);
      return (a & ~PAGE_MASK) | ((a + ADDR_BITS'(1)) & PAGE_MASK);
   endfunction

   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sclk_prev_q, cs_prev_q;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;

   logic [2:0]           state_q, state_d;
   logic [4:0]           bit_cnt_q, bit_cnt_d;
   logic [6:0]           shift_q, shift_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic                 is_write_q, is_write_d;
   logic                 wr_armed_q, wr_armed_d;
   logic                 wr_any_q, wr_any_d;
   logic                 wren_pend_q, wren_pend_d;
   logic [2:0]           out_cnt_q, out_cnt_d;
   logic [7:0]           tx_q, tx_d;
   logic                 miso_q, miso_d;
   logic                 oe_q, oe_d;
   logic                 wip_q, wip_d;
   logic                 wel_q, wel_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [7:0]           last_cmd_q, last_cmd_d;

   logic [7:0] rx_byte_s, status_s, load_byte_s;
   logic       mem_we_s, prog_start_s;

   logic [7:0] mem_q [DEPTH] = '{default: 8'hFF};

   assign sclk_s       = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s         = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s       = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise_s  = sclk_s & ~sclk_prev_q;
   assign sclk_fall_s  = ~sclk_s & sclk_prev_q;
   assign cs_rise_s    = cs_s & ~cs_prev_q;
   assign cs_fall_s    = ~cs_s & cs_prev_q;
   assign rx_byte_s    = {shift_q, mosi_s};
   assign status_s     = {6'b000000, wel_q, wip_q};
   assign load_byte_s  = (state_q == S_STATUS) ? status_s : mem_q[addr_q];
   assign prog_start_s = wr_armed_q & wr_any_q;

   // Pin synchronizers and edge-detect history.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
      end
   end

   // Next-state logic: program timer, transaction FSM, shift paths.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      addr_d      = addr_q;
      is_write_d  = is_write_q;
      wr_armed_d  = wr_armed_q;
      wr_any_d    = wr_any_q;
      wren_pend_d = wren_pend_q;
      out_cnt_d   = out_cnt_q;
      tx_d        = tx_q;
      miso_d      = miso_q;
      oe_d        = oe_q;
      wip_d       = wip_q;
      wel_d       = wel_q;
      timer_d     = timer_q;
      last_cmd_d  = last_cmd_q;
      mem_we_s    = 1'b0;

      // Program completion clears WIP and WEL together.
      if (wip_q && (timer_q <= TW'(1))) begin
         wip_d   = 1'b0;
         wel_d   = 1'b0;
         timer_d = '0;
      end else if (wip_q) begin
         timer_d = timer_q - TW'(1);
      end else begin
         timer_d = timer_q;
      end

      if (cs_rise_s) begin
         state_d = S_IDLE;
         oe_d    = 1'b0;
         miso_d  = 1'b1;
         wel_d   = wel_d | wren_pend_q;
         wip_d   = wip_d | prog_start_s;
         timer_d = prog_start_s ? TW'(PROG_CYCLES) : timer_d;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cs_fall_s) begin
                  state_d     = S_CMD;
                  bit_cnt_d   = '0;
                  out_cnt_d   = '0;
                  is_write_d  = 1'b0;
                  wr_armed_d  = 1'b0;
                  wr_any_d    = 1'b0;
                  wren_pend_d = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_CMD: begin
               if (sclk_rise_s) begin
                  shift_d   = rx_byte_s[6:0];
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d   = '0;
                     last_cmd_d  = rx_byte_s;
                     state_d     = dispatch(rx_byte_s, wip_q);
                     is_write_d  = (rx_byte_s == OP_WRITE);
                     wr_armed_d  = (rx_byte_s == OP_WRITE) && wel_q && !wip_q;
                     wren_pend_d = (rx_byte_s == OP_WREN) && !wip_q;
                  end else begin
                     state_d = S_CMD;
                  end
               end else begin
                  state_d = S_CMD;
               end
            end
            S_ADDR: begin
               if (sclk_rise_s) begin
                  addr_d    = {addr_q[ADDR_BITS-2:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd23) begin
                     bit_cnt_d = '0;
                     state_d   = is_write_q ? S_WDATA : S_RDATA;
                  end else begin
                     state_d = S_ADDR;
                  end
               end else begin
                  state_d = S_ADDR;
               end
            end
            S_STATUS, S_RDATA: begin
               // A new byte (status re-sampled, or array data) is loaded at each byte boundary.
               if (sclk_fall_s) begin
                  oe_d      = 1'b1;
                  out_cnt_d = out_cnt_q + 3'd1;
                  if (out_cnt_q == 3'd0) begin
                     miso_d = load_byte_s[7];
                     tx_d   = {load_byte_s[6:0], 1'b0};
                     addr_d = (state_q == S_RDATA) ? addr_q + ADDR_BITS'(1) : addr_q;
                  end else begin
                     miso_d = tx_q[7];
                     tx_d   = {tx_q[6:0], 1'b0};
                  end
               end else begin
                  oe_d = oe_q;
               end
            end
            S_WDATA: begin
               if (sclk_rise_s) begin
                  shift_d   = rx_byte_s[6:0];
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = '0;
                     mem_we_s  = wr_armed_q;
                     wr_any_d  = wr_any_q | wr_armed_q;
                     addr_d    = wr_armed_q ? page_inc(addr_q) : addr_q;
                  end else begin
                     state_d = S_WDATA;
                  end
               end else begin
                  state_d = S_WDATA;
               end
            end
            S_IGNORE: begin
               state_d = S_IGNORE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Control and status registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         addr_q      <= '0;
         is_write_q  <= 1'b0;
         wr_armed_q  <= 1'b0;
         wr_any_q    <= 1'b0;
         wren_pend_q <= 1'b0;
         out_cnt_q   <= '0;
         tx_q        <= '0;
         miso_q      <= 1'b1;
         oe_q        <= 1'b0;
         wip_q       <= 1'b0;
         wel_q       <= 1'b0;
         timer_q     <= '0;
         last_cmd_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         addr_q      <= addr_d;
         is_write_q  <= is_write_d;
         wr_armed_q  <= wr_armed_d;
         wr_any_q    <= wr_any_d;
         wren_pend_q <= wren_pend_d;
         out_cnt_q   <= out_cnt_d;
         tx_q        <= tx_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         wip_q       <= wip_d;
         wel_q       <= wel_d;
         timer_q     <= timer_d;
         last_cmd_q  <= last_cmd_d;
      end
   end

   // Array storage survives n_rst.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[addr_q] <= rx_byte_s;
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = oe_q;
   assign busy        = wip_q;
   assign last_cmd    = last_cmd_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: bit-banged SPI mode-0 transactions with hand-computed results.
module tb_spi_flash_responder;
   logic       clk;
   logic       n_rst;
   logic       spi_sclk;
   logic       spi_cs_n;
   logic       spi_mosi;
   logic       spi_miso;
   logic       spi_miso_oe;
   logic       busy;
   logic [7:0] last_cmd;

   int total = 0;
   int bad   = 0;

   spi_flash_responder #(
      .ADDR_BITS  (8),
      .PROG_CYCLES(1000),
      .SYNC_STAGES(2)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .spi_sclk   (spi_sclk),
      .spi_cs_n   (spi_cs_n),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .spi_miso_oe(spi_miso_oe),
      .busy       (busy),
      .last_cmd   (last_cmd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // sclk half period is 4 clk; MISO is sampled just before each rising sclk.
   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic oe_any);
      rx     = 8'h00;
      oe_any = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = tx[i];
         #40;
         rx[i]    = spi_miso;
         oe_any   = oe_any | spi_miso_oe;
         spi_sclk = 1'b1;
         #40;
         spi_sclk = 1'b0;
      end
   endtask

   task automatic xbits(input logic [7:0] tx, input int n);
      for (int i = 7; i >= 8 - n; i--) begin
         spi_mosi = tx[i];
         #40;
         spi_sclk = 1'b1;
         #40;
         spi_sclk = 1'b0;
      end
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      #40;
   endtask

   task automatic cs_high();
      #40;
      spi_cs_n = 1'b1;
      #80;
   endtask

   task automatic pulse_reset();
      n_rst = 1'b0;
      #20;
      n_rst = 1'b1;
      #40;
   endtask

   task automatic do_wren();
      logic [7:0] r;
      logic       o;
      cs_low();
      xfer(8'h06, r, o);
      cs_high();
   endtask

   task automatic do_rdsr(output logic [7:0] s0, output logic [7:0] s1);
      logic [7:0] r;
      logic       o;
      cs_low();
      xfer(8'h05, r, o);
      xfer(8'h00, s0, o);
      xfer(8'h00, s1, o);
      cs_high();
   endtask

   task automatic do_read(input logic [23:0] a, output logic [7:0] d0, output logic [7:0] d1,
                          output logic oe_any);
      logic [7:0] r;
      logic       o0, o1;
      cs_low();
      xfer(8'h03, r, o0);
      xfer(a[23:16], r, o0);
      xfer(a[15:8], r, o0);
      xfer(a[7:0], r, o0);
      xfer(8'h00, d0, o0);
      xfer(8'h00, d1, o1);
      oe_any = o0 | o1;
      cs_high();
   endtask

   task automatic do_write(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1,
                           input int n);
      logic [7:0] r;
      logic       o;
      cs_low();
      xfer(8'h02, r, o);
      xfer(a[23:16], r, o);
      xfer(a[15:8], r, o);
      xfer(a[7:0], r, o);
      if (n > 0) xfer(d0, r, o);
      if (n > 1) xfer(d1, r, o);
      cs_high();
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy === 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, n);
      end
   endtask

   task automatic test_reset();
      total++;
      if (spi_miso !== 1'b1) begin bad++; $display("FAIL reset_miso: got %b expected 1", spi_miso); end
      total++;
      if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b expected 0", spi_miso_oe); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      total++;
      if (last_cmd !== 8'h00) begin bad++; $display("FAIL reset_last_cmd: got %h expected 00", last_cmd); end
   endtask

   task automatic test_wren_rdsr();
      logic [7:0] s0, s1;
      do_wren();
      do_rdsr(s0, s1);
      total++;
      if (s0 !== 8'h02) begin bad++; $display("FAIL wren_rdsr_b0: got %h expected 02", s0); end
      total++;
      if (s1 !== 8'h02) begin bad++; $display("FAIL wren_rdsr_b1: got %h expected 02", s1); end
      total++;
      if (last_cmd !== 8'h05) begin bad++; $display("FAIL wren_last_cmd: got %h expected 05", last_cmd); end
   endtask

   task automatic test_write_no_wren();
      logic [7:0] s0, s1, d0, d1;
      logic       oe;
      pulse_reset();
      do_write(24'h000000, 8'hDE, 8'hAD, 2);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL nowren_busy: got %b expected 0", busy); end
      total++;
      if (last_cmd !== 8'h02) begin bad++; $display("FAIL nowren_last_cmd: got %h expected 02", last_cmd); end
      do_rdsr(s0, s1);
      total++;
      if (s0 !== 8'h00) begin bad++; $display("FAIL nowren_status: got %h expected 00", s0); end
      do_read(24'h000000, d0, d1, oe);
      total++;
      if (d0 !== 8'hFF) begin bad++; $display("FAIL nowren_rd0: got %h expected FF", d0); end
      total++;
      if (d1 !== 8'hFF) begin bad++; $display("FAIL nowren_rd1: got %h expected FF", d1); end
      total++;
      if (oe !== 1'b1) begin bad++; $display("FAIL nowren_read_oe: got %b expected 1", oe); end
   endtask

   task automatic test_program();
      logic [7:0] s0, s1, d0, d1;
      logic       oe;
      do_wren();
      do_write(24'h000010, 8'hDE, 8'hAD, 2);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL prog_busy: got %b expected 1", busy); end
      do_read(24'h000010, d0, d1, oe);
      total++;
      if (oe !== 1'b0) begin bad++; $display("FAIL wip_read_oe: got %b expected 0", oe); end
      do_wren();
      do_rdsr(s0, s1);
      total++;
      if (s0 !== 8'h03) begin bad++; $display("FAIL wip_status_b0: got %h expected 03", s0); end
      total++;
      if (s1 !== 8'h03) begin bad++; $display("FAIL wip_status_b1: got %h expected 03", s1); end
      wait_idle();
      do_rdsr(s0, s1);
      total++;
      if (s0 !== 8'h00) begin bad++; $display("FAIL done_status: got %h expected 00", s0); end
      do_read(24'h000010, d0, d1, oe);
      total++;
      if (d0 !== 8'hDE) begin bad++; $display("FAIL prog_rd0: got %h expected DE", d0); end
      total++;
      if (d1 !== 8'hAD) begin bad++; $display("FAIL prog_rd1: got %h expected AD", d1); end
   endtask

   task automatic test_wrap();
      logic [7:0] d0, d1;
      logic       oe;
      do_wren();
      do_write(24'h0000FF, 8'h5A, 8'hC3, 2);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL wrap_busy: got %b expected 1", busy); end
      wait_idle();
      do_read(24'h0000FF, d0, d1, oe);
      total++;
      if (d0 !== 8'h5A) begin bad++; $display("FAIL wrap_rd0: got %h expected 5A", d0); end
      total++;
      if (d1 !== 8'hC3) begin bad++; $display("FAIL wrap_rd1: got %h expected C3", d1); end
   endtask

   task automatic test_zero_write();
      logic [7:0] s0, s1;
      do_wren();
      do_write(24'h000030, 8'h00, 8'h00, 0);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL zero_write_busy: got %b expected 0", busy); end
      do_rdsr(s0, s1);
      total++;
      if (s0 !== 8'h02) begin bad++; $display("FAIL zero_write_status: got %h expected 02", s0); end
   endtask

   task automatic test_abort();
      logic [7:0] r, s0, s1, d0, d1;
      logic       o;
      pulse_reset();
      cs_low();
      xfer(8'h03, r, o);
      xbits(8'h00, 8);
      xbits(8'h00, 4);
      cs_high();
      total++;
      if (last_cmd !== 8'h03) begin bad++; $display("FAIL abort_last_cmd: got %h expected 03", last_cmd); end
      do_rdsr(s0, s1);
      total++;
      if (s0 !== 8'h00) begin bad++; $display("FAIL abort_status: got %h expected 00", s0); end
      total++;
      if (last_cmd !== 8'h05) begin bad++; $display("FAIL abort_rdsr_cmd: got %h expected 05", last_cmd); end
      do_wren();
      do_write(24'h000020, 8'h77, 8'h00, 1);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL rst_wip_busy_pre: got %b expected 1", busy); end
      pulse_reset();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_wip_busy: got %b expected 0", busy); end
      do_rdsr(s0, s1);
      total++;
      if (s0 !== 8'h00) begin bad++; $display("FAIL rst_wip_status: got %h expected 00", s0); end
      do_read(24'h000020, d0, d1, o);
      total++;
      if (d0 !== 8'h77) begin bad++; $display("FAIL rst_keep_rd0: got %h expected 77", d0); end
      total++;
      if (d1 !== 8'hFF) begin bad++; $display("FAIL rst_keep_rd1: got %h expected FF", d1); end
   endtask

   initial begin
      n_rst    = 1'b0;
      spi_sclk = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      #40;
      n_rst = 1'b1;
      #40;
      test_reset();
      test_wren_rdsr();
      test_write_no_wren();
      test_program();
      test_wrap();
      test_zero_write();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
